// File: rtl/addr_key_pkg.sv
// Shared types and constants for addr_key_sequencer: FSM state encoding,
// decoded-access struct, and the 8-bit Galois response LFSR step function.
package addr_key_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MATCH    = 2'd1,
    UNLOCKED = 2'd2
  } state_e;

  // One decoded bus access: in-window hit, qualified read, qualified write
  typedef struct packed {
    logic hit;
    logic qrd;
    logic qwr;
  } acc_dec_t;

  localparam logic [7:0] LFSR_TAPS     = 8'hB8;
  localparam logic [7:0] LFSR_SEED_DEF = 8'h01;

  // Galois step: shift right, fold taps in when the bit shifted out is 1
  function automatic logic [7:0] lfsr_step(input logic [7:0] s);
    return {1'b0, s[7:1]} ^ (s[0] ? LFSR_TAPS : 8'h00);
  endfunction

  // Seed from the last key address; an all-zero nibble would lock the LFSR
  function automatic logic [7:0] lfsr_seed(input logic [3:0] lo);
    return (lo == 4'h0) ? LFSR_SEED_DEF : {4'h0, lo};
  endfunction

endpackage

// File: rtl/resp_lfsr.sv
// 8-bit Galois response LFSR. load has priority over adv.
module resp_lfsr
  import addr_key_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [7:0] seed,
  input  logic       adv,
  output logic [7:0] q
);

  // LFSR state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    q <= LFSR_SEED_DEF;
    else if (load) q <= seed;
    else if (adv)  q <= lfsr_step(q);
  end

endmodule

// File: rtl/addr_key_sequencer.sv
// Address-sequence key matcher with LFSR read responses.
// Qualified reads in the decoded window walk a KEY_LEN-step nibble key; on
// completion the block answers RESP_CNT reads with LFSR bits, then relocks.
// Optional idle timeout enabled by defining ADDR_KEY_TIMEOUT_EN.
module addr_key_sequencer
  import addr_key_pkg::*;
#(
  parameter int                       ADDR_W   = 14,
  parameter int                       WIN_MSB  = 13,
  parameter int                       WIN_W    = 2,
  parameter logic [WIN_W-1:0]         WIN_VAL  = 2'b01,
  parameter int                       KEY_LSB  = 4,
  parameter int                       NIB_W    = 4,
  parameter int                       KEY_LEN  = 8,
  parameter logic [KEY_LEN*NIB_W-1:0] KEY      = 32'h9E3C5A71,
  parameter int                       RESP_W   = 2,
  parameter int                       RESP_CNT = 16,
  parameter int                       TIMEOUT  = 255,
  localparam int                      SW       = $clog2(KEY_LEN+1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              acc_vld,
  input  logic              sser_n,
  input  logic [ADDR_W-1:0] ba,
  input  logic              br_w,
  output logic              rd_oe,
  output logic [RESP_W-1:0] rd_data,
  output logic              unlocked,
  output logic [SW-1:0]     step,
  output logic              key_err
);

  localparam int CW = $clog2(RESP_CNT+1);

  state_e           state;
  logic [SW-1:0]    step_q;
  logic [CW-1:0]    resp_cnt;
  logic             key_err_q;
  acc_dec_t         dec;
  logic [NIB_W-1:0] nib;
  logic [NIB_W-1:0] exp_nib;
  logic             nib_ok;
  logic             last_step;
  logic             lfsr_load;
  logic             lfsr_adv;
  logic [7:0]       lfsr_q;
  logic             to_fire;
  logic             unused_ba;

  assign dec.hit = acc_vld & ~sser_n & (ba[WIN_MSB -: WIN_W] == WIN_VAL);
  assign dec.qrd = dec.hit &  br_w;
  assign dec.qwr = dec.hit & ~br_w;

  assign nib       = ba[KEY_LSB +: NIB_W];
  // Only consulted while step_q < KEY_LEN (IDLE/MATCH)
  assign exp_nib   = KEY[int'(step_q)*NIB_W +: NIB_W];
  assign nib_ok    = (nib == exp_nib);
  assign last_step = (step_q == SW'(KEY_LEN-1));

  assign lfsr_load = dec.qrd & (state != UNLOCKED) & nib_ok & last_step;
  assign lfsr_adv  = dec.qrd & (state == UNLOCKED);

  assign rd_oe    = lfsr_adv;
  assign rd_data  = lfsr_q[RESP_W-1:0];
  assign unlocked = (state == UNLOCKED);
  assign step     = step_q;
  assign key_err  = key_err_q;

  // Bits of ba outside the decoded fields are don't-care here
  assign unused_ba = ^ba;

  resp_lfsr u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (lfsr_load),
    .seed  (lfsr_seed(ba[3:0])),
    .adv   (lfsr_adv),
    .q     (lfsr_q)
  );

`ifdef ADDR_KEY_TIMEOUT_EN
  logic [7:0] idle_cnt;

  assign to_fire = (state != IDLE) & ~dec.hit & (idle_cnt == 8'(TIMEOUT-1));

  // Idle clocks since the last hit while a key or response session is open
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                   idle_cnt <= '0;
    else if (dec.hit || state == IDLE || to_fire) idle_cnt <= '0;
    else                                          idle_cnt <= idle_cnt + 8'd1;
  end
`else
  assign to_fire = 1'b0;
`endif

  // Key/response FSM with step and response counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      step_q    <= '0;
      resp_cnt  <= '0;
      key_err_q <= 1'b0;
    end else begin
      key_err_q <= 1'b0;
      if (dec.qwr) begin
        // Any window write aborts; silent only if nothing was in progress
        state     <= IDLE;
        step_q    <= '0;
        key_err_q <= !(state == IDLE && step_q == '0);
      end else if (dec.qrd) begin
        case (state)
          IDLE, MATCH: begin
            if (nib_ok) begin
              step_q <= step_q + 1'b1;
              if (last_step) begin
                state    <= UNLOCKED;
                resp_cnt <= '0;
              end else begin
                state <= MATCH;
              end
            end else if (state == MATCH) begin
              if (nib == KEY[NIB_W-1:0]) begin
                // Wrong step but a valid first step: restart the key
                step_q <= SW'(1);
              end else begin
                state     <= IDLE;
                step_q    <= '0;
                key_err_q <= 1'b1;
              end
            end
          end
          UNLOCKED: begin
            if (resp_cnt == CW'(RESP_CNT-1)) begin
              state    <= IDLE;
              step_q   <= '0;
              resp_cnt <= '0;
            end else begin
              resp_cnt <= resp_cnt + 1'b1;
            end
          end
          default: begin
            state  <= IDLE;
            step_q <= '0;
          end
        endcase
      end else if (to_fire) begin
        state     <= IDLE;
        step_q    <= '0;
        key_err_q <= 1'b1;
      end
    end
  end

endmodule
